// File: rtl/l_key_unpack.sv
// l_key_unpack: reads L words back and regenerates little-endian key bytes K[i] = byte (i mod U) of L[i/U]
module l_key_unpack #(
  parameter int B = 16,
  parameter int W = 32,
  parameter int U = 4,
  parameter int C = 4,
  parameter int B_length = $clog2(B),
  parameter int C_length = $clog2(C)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic [C_length-1:0] L_address,
  input  logic [W-1:0] L_sub_i,
  output logic [B_length-1:0] key_address,
  output logic [7:0] key_sub_o,
  output logic key_we,
  output logic busy,
  output logic done
);
  localparam int KW = U > 1 ? $clog2(U) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_ADDR, READ_DATA, WRITE_DATA, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k, k_n;
  logic [W-1:0] shreg, shreg_n;
  logic [C_length-1:0] l_n;
  logic [B_length-1:0] ka_n;
  logic [7:0] ks_n;
  logic we_n, busy_n, done_n;
  // L_address doubles as the word index j; outputs are registered from next-state values
  always_comb begin
    state_n = state;
    k_n = k;
    shreg_n = shreg;
    l_n = L_address;
    ka_n = key_address;
    ks_n = key_sub_o;
    we_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = WAIT_ADDR;
        l_n = '0;
        k_n = '0;
        busy_n = 1'b1;
      end
      WAIT_ADDR: state_n = READ_DATA;
      READ_DATA: begin
        state_n = WRITE_DATA;
        we_n = 1'b1;
        k_n = '0;
        ka_n = B_length'(int'(L_address) * U);
        ks_n = L_sub_i[7:0];
        shreg_n = L_sub_i >> 8;
      end
      WRITE_DATA: if (key_address == B_length'(B - 1)) begin
        state_n = DONE;
        busy_n = 1'b0;
        done_n = 1'b1;
      end else if (k == KW'(U - 1)) begin
        state_n = WAIT_ADDR;
        l_n = L_address + 1'b1;
      end else begin
        we_n = 1'b1;
        k_n = k + 1'b1;
        ka_n = key_address + 1'b1;
        ks_n = shreg[7:0];
        shreg_n = shreg >> 8;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      k <= '0;
      shreg <= '0;
      L_address <= '0;
      key_address <= '0;
      key_sub_o <= '0;
      key_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      shreg <= shreg_n;
      L_address <= l_n;
      key_address <= ka_n;
      key_sub_o <= ks_n;
      key_we <= we_n;
      busy <= busy_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_l_key_unpack.sv
// tb_l_key_unpack: packs keys into L words, unpacks them through two DUT configurations and checks timing and bytes
module tb_l_key_unpack;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, sel = 1'b0;
  logic [1:0] la_a, la_b, la;
  logic [3:0] ka_a, ka_b, ka;
  logic [7:0] ks_a, ks_b, ks;
  logic we_a, we_b, we, busy_a, busy_b, busy, done_a, done_b, done;
  logic [31:0] rd_a, rd_b;
  logic [31:0] lm [4];
  logic [7:0] key [16];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    rd_a <= lm[la_a];
    rd_b <= lm[la_b];
  end

  l_key_unpack dut_a (.clk(clk), .rst(rst), .start(start & !sel), .L_address(la_a), .L_sub_i(rd_a),
    .key_address(ka_a), .key_sub_o(ks_a), .key_we(we_a), .busy(busy_a), .done(done_a));
  l_key_unpack #(.B(10), .W(32), .U(4), .C(3)) dut_b (.clk(clk), .rst(rst), .start(start & sel),
    .L_address(la_b), .L_sub_i(rd_b), .key_address(ka_b), .key_sub_o(ks_b), .key_we(we_b),
    .busy(busy_b), .done(done_b));

  assign la = sel ? la_b : la_a;
  assign ka = sel ? ka_b : ka_a;
  assign ks = sel ? ks_b : ks_a;
  assign we = sel ? we_b : we_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;

  function automatic int wcyc(input int i);
    return 3 + (i / 4) * 6 + i % 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zeros(input string tag);
    check({tag, "_we"}, we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ka"}, ka, 0);
    check({tag, "_ks"}, ks, 0);
    check({tag, "_la"}, la, 0);
  endtask

  task automatic pack(input int nb);
    for (int w = 0; w < 4; w++) lm[w] = 32'h0;
    for (int i = nb - 1; i >= 0; i--) lm[i / 4] = (lm[i / 4] << 8) + 32'(key[i]);
  endtask

  // called at a negedge with the DUT idle: that cycle is cycle 0
  task automatic run(input int rc, input bit hold, input bit poke);
    int nb, dc, last, cc, ei, em;
    bit ab, ewe;
    int cnt [16];
    logic [7:0] got [16];
    nb = sel ? 10 : 16;
    dc = wcyc(nb - 1) + 1;
    last = hold ? 2 * dc + 2 : dc + 2;
    for (int a = 0; a < 16; a++) begin
      cnt[a] = 0;
      got[a] = 8'h0;
    end
    start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      cc = hold ? c % (dc + 1) : c;
      ab = rc > 0 && c > rc;
      ewe = 1'b0;
      ei = 0;
      for (int i = 0; i < nb; i++) if (wcyc(i) == cc) begin
        ewe = !ab;
        ei = i;
      end
      check("key_we", we, ewe);
      if (ewe) begin
        check("key_address", ka, ei);
        check("key_sub_o", ks, key[ei]);
      end
      check("busy", busy, !ab && cc >= 1 && cc < dc);
      check("done", done, !ab && cc == dc);
      if (!ab && cc >= 1 && cc < dc && (cc - 1) % 6 == 0) check("L_address", la, (cc - 1) / 6);
      if (ab && c == rc + 1) zeros("abort");
      if (we === 1'b1) begin
        cnt[ka]++;
        got[ka] = ks;
      end
      start = hold || (poke && (c == 10 || c == dc));
      rst = !(c == rc);
    end
    start = 1'b0;
    for (int a = 0; a < 16; a++) begin
      em = (a < nb && (rc <= 0 || wcyc(a) <= rc)) ? (hold ? 2 : 1) : 0;
      check("write_count", cnt[a], em);
      if (em > 0) check("key_mem", got[a], key[a]);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int w = 0; w < 4; w++) lm[w] = 32'h0;
    repeat (3) @(negedge clk);
    zeros("reset");
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) key[i] = 8'(i);
    pack(16);
    run(0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) key[i] = 8'($urandom);
      pack(16);
      run(0, 0, n == 3);
    end
    sel = 1'b1;
    for (int i = 0; i < 16; i++) key[i] = 8'(i + 8'h40);
    key[8] = 8'hAA;
    key[9] = 8'hBB;
    pack(10);
    lm[2] = 32'hDDCCBBAA;
    run(0, 0, 0);
    run(16, 0, 0);
    run(0, 0, 1);
    sel = 1'b0;
    for (int i = 0; i < 16; i++) key[i] = 8'($urandom);
    pack(16);
    run(10, 0, 0);
    run(0, 1, 0);
    rst = 1'b0;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      zeros("rst_start");
    end
    rst = 1'b1;
    run(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
